// File: rtl/pspin_ctrl_pkg.sv
// PsPIN control register file: register map and fixed read values.
package pspin_ctrl_pkg;

  // Byte offsets of the register map
  localparam int FETCH_EN_OFF     = 'h0000;
  localparam int CTRL_OFF         = 'h0004;
  localparam int EOC_OFF          = 'h0100;
  localparam int BUSY_OFF         = 'h0104;
  localparam int EOC_STICKY_OFF   = 'h0108;
  localparam int STDOUT_EMPTY_OFF = 'h010C;
  localparam int MPQ_FULL_OFF     = 'h0200;
  localparam int STDOUT_POP_OFF   = 'h1000;

  // CTRL register bit positions
  localparam int CTRL_AUX_RST_BIT = 0;
  localparam int CTRL_FLUSH_BIT   = 1;

  // Fixed read values: unmapped / FIFO-in-reset, and empty FIFO
  localparam logic [31:0] UNMAPPED_DATA = 32'hFFFF_FFFF;
  localparam logic [31:0] EMPTY_DATA    = 32'h0000_0000;

  // Byte offset to 32-bit word index
  function automatic int word_idx(input int off);
    return off / 4;
  endfunction

endpackage

// File: rtl/pspin_ctrl_sticky.sv
// Sticky end-of-computation flags: set on a rising edge of the (already
// registered) level input, cleared by write-1; a coincident set beats clear.
module pspin_ctrl_sticky #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] lvl_i,
  input  logic [WIDTH-1:0] clr_i,
  output logic [WIDTH-1:0] sticky_o
);

  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] sticky_q, sticky_d;
  logic [WIDTH-1:0] rise;

  assign rise = lvl_i & ~prev_q;

  // Clear first, then OR in new edges so set wins on collision
  always_comb begin
    sticky_d = (sticky_q & ~clr_i) | rise;
  end

  // Edge-detect history and flag state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q   <= '0;
      sticky_q <= '0;
    end else begin
      prev_q   <= lvl_i;
      sticky_q <= sticky_d;
    end
  end

  assign sticky_o = sticky_q;

endmodule

// File: rtl/pspin_ctrl_regfile.sv
// PsPIN control/status register file on the reg-side of the AXI-Lite bridge.
// Single-cycle read/write acks, registered status sampling, stdout FIFO pops.
module pspin_ctrl_regfile
  import pspin_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH   = 16,
  parameter int DATA_WIDTH   = 32,
  parameter int STRB_WIDTH   = DATA_WIDTH/8,
  parameter int NUM_CLUSTERS = 2,
  parameter int NUM_MPQ      = 256,
  parameter int NUM_STDOUT   = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   reg_wr_addr,
  input  logic [DATA_WIDTH-1:0]   reg_wr_data,
  input  logic [STRB_WIDTH-1:0]   reg_wr_strb,
  input  logic                    reg_wr_en,
  output logic                    reg_wr_ack,
  output logic                    reg_wr_wait,
  input  logic [ADDR_WIDTH-1:0]   reg_rd_addr,
  input  logic                    reg_rd_en,
  output logic [DATA_WIDTH-1:0]   reg_rd_data,
  output logic                    reg_rd_ack,
  output logic                    reg_rd_wait,
  output logic [NUM_CLUSTERS-1:0] cl_fetch_en_o,
  output logic                    aux_rst_o,
  output logic                    stdout_flush_o,
  input  logic [NUM_CLUSTERS-1:0] cl_eoc_i,
  input  logic [NUM_CLUSTERS-1:0] cl_busy_i,
  input  logic [NUM_MPQ-1:0]      mpq_full_i,
  output logic [NUM_STDOUT-1:0]   stdout_rd_en,
  input  logic [NUM_STDOUT-1:0]   stdout_empty,
  input  logic [NUM_STDOUT-1:0]   stdout_rd_rst_busy,
  input  logic [32*NUM_STDOUT-1:0] stdout_dout
);

  localparam int NW = (NUM_MPQ + 31) / 32;

  logic [NUM_CLUSTERS-1:0] fetch_q, fetch_d;
  logic                    aux_q, aux_d;
  logic                    flush_q, flush_d;
  logic                    wr_ack_q, rd_ack_q;
  logic [DATA_WIDTH-1:0]   rd_data_q, rd_data_d;
  logic [NUM_STDOUT-1:0]   pop_q, pop_d;
  logic [NUM_CLUSTERS-1:0] eoc_q, busy_q, sticky, sticky_clr;
  logic [NUM_MPQ-1:0]      mpq_q;
  logic [NUM_STDOUT-1:0]   empty_q;
  logic [NW*32-1:0]        mpq_pad;
  logic [DATA_WIDTH-1:0]   wmask;
  int                      rd_w, wr_w;
  logic                    unused_bits;

  assign rd_w = int'(reg_rd_addr[ADDR_WIDTH-1:2]);
  assign wr_w = int'(reg_wr_addr[ADDR_WIDTH-1:2]);

  // Byte-address low bits and write-data bits outside any field are don't-care
  assign unused_bits = ^{reg_rd_addr[1:0], reg_wr_addr[1:0], reg_wr_data, wmask};

  // Status inputs sampled once; reads always see the 1-cycle-old sample
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      eoc_q   <= '0;
      busy_q  <= '0;
      mpq_q   <= '0;
      empty_q <= '0;
    end else begin
      eoc_q   <= cl_eoc_i;
      busy_q  <= cl_busy_i;
      mpq_q   <= mpq_full_i;
      empty_q <= stdout_empty;
    end
  end

  // Zero-pad MPQ flags to whole words so bits past NUM_MPQ read as 0
  always_comb begin
    mpq_pad = '0;
    mpq_pad[NUM_MPQ-1:0] = mpq_q;
  end

  // Expand byte strobes into a bit mask
  always_comb begin
    wmask = '0;
    for (int b = 0; b < STRB_WIDTH; b++) wmask[8*b +: 8] = {8{reg_wr_strb[b]}};
  end

  pspin_ctrl_sticky #(
    .WIDTH (NUM_CLUSTERS)
  ) u_eoc_sticky (
    .clk      (clk),
    .rst      (rst),
    .lvl_i    (eoc_q),
    .clr_i    (sticky_clr),
    .sticky_o (sticky)
  );

  // Read mux; stdout reads decide pop from the live FIFO flags
  always_comb begin
    rd_data_d = UNMAPPED_DATA;
    pop_d     = '0;
    if (rd_w == word_idx(FETCH_EN_OFF)) begin
      rd_data_d = '0;
      rd_data_d[NUM_CLUSTERS-1:0] = fetch_q;
    end else if (rd_w == word_idx(CTRL_OFF)) begin
      rd_data_d = '0;
      rd_data_d[CTRL_AUX_RST_BIT] = aux_q;
    end else if (rd_w == word_idx(EOC_OFF)) begin
      rd_data_d = '0;
      rd_data_d[NUM_CLUSTERS-1:0] = eoc_q;
    end else if (rd_w == word_idx(BUSY_OFF)) begin
      rd_data_d = '0;
      rd_data_d[NUM_CLUSTERS-1:0] = busy_q;
    end else if (rd_w == word_idx(EOC_STICKY_OFF)) begin
      rd_data_d = '0;
      rd_data_d[NUM_CLUSTERS-1:0] = sticky;
    end else if (rd_w == word_idx(STDOUT_EMPTY_OFF)) begin
      rd_data_d = '0;
      rd_data_d[NUM_STDOUT-1:0] = empty_q;
    end
    for (int k = 0; k < NW; k++) begin
      if (rd_w == word_idx(MPQ_FULL_OFF) + k) rd_data_d = mpq_pad[32*k +: 32];
    end
    for (int n = 0; n < NUM_STDOUT; n++) begin
      if (rd_w == word_idx(STDOUT_POP_OFF) + n) begin
        if (stdout_rd_rst_busy[n]) begin
          rd_data_d = UNMAPPED_DATA;
        end else if (stdout_empty[n]) begin
          rd_data_d = EMPTY_DATA;
        end else begin
          rd_data_d = stdout_dout[32*n +: 32];
          pop_d[n]  = 1'b1;
        end
      end
    end
  end

  // Read ack/data/pop: one cycle after rd_en; data held until the next read
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ack_q  <= 1'b0;
      rd_data_q <= '0;
      pop_q     <= '0;
    end else begin
      rd_ack_q <= reg_rd_en;
      pop_q    <= reg_rd_en ? pop_d : '0;
      if (reg_rd_en) rd_data_q <= rd_data_d;
    end
  end

  // Write decode; RO and unmapped addresses fall through unchanged
  always_comb begin
    fetch_d    = fetch_q;
    aux_d      = aux_q;
    flush_d    = 1'b0;
    sticky_clr = '0;
    if (reg_wr_en) begin
      if (wr_w == word_idx(FETCH_EN_OFF))
        fetch_d = (fetch_q & ~wmask[NUM_CLUSTERS-1:0]) |
                  (reg_wr_data[NUM_CLUSTERS-1:0] & wmask[NUM_CLUSTERS-1:0]);
      if (wr_w == word_idx(CTRL_OFF)) begin
        if (reg_wr_strb[0]) aux_d = reg_wr_data[CTRL_AUX_RST_BIT];
        flush_d = reg_wr_strb[0] & reg_wr_data[CTRL_FLUSH_BIT];
      end
      if (wr_w == word_idx(EOC_STICKY_OFF))
        sticky_clr = reg_wr_data[NUM_CLUSTERS-1:0] & wmask[NUM_CLUSTERS-1:0];
    end
  end

  // Control registers, flush pulse and write ack
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_q  <= '0;
      aux_q    <= 1'b0;
      flush_q  <= 1'b0;
      wr_ack_q <= 1'b0;
    end else begin
      fetch_q  <= fetch_d;
      aux_q    <= aux_d;
      flush_q  <= flush_d;
      wr_ack_q <= reg_wr_en;
    end
  end

  assign reg_wr_ack     = wr_ack_q;
  assign reg_wr_wait    = 1'b0;
  assign reg_rd_ack     = rd_ack_q;
  assign reg_rd_data    = rd_data_q;
  assign reg_rd_wait    = 1'b0;
  assign cl_fetch_en_o  = fetch_q;
  assign aux_rst_o      = aux_q;
  assign stdout_flush_o = flush_q;
  assign stdout_rd_en   = pop_q;

endmodule
